// File: rtl/datapath_pkg.sv
// Shared definitions for the 16-bit datapath pipeline stages: field widths,
// payload sizing and ID/EX skid-stage state encoding.
package datapath_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int REG_W_DEF     = 4;
    localparam int CTRL_W_DEF    = 12;
    localparam int PAYLOAD_W_DEF = 3 * DATA_W_DEF + 4 * REG_W_DEF + CTRL_W_DEF;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } idex_state_e;

    function automatic int payload_w(input int data_w, input int reg_w, input int ctrl_w);
        return 3 * data_w + 4 * reg_w + ctrl_w;
    endfunction

endpackage

// File: rtl/idex_payload_reg.sv
// Width-parametrised payload register with synchronous clear (priority) and load enable.
module idex_payload_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Payload storage: clear wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= {W{1'b0}};
        end else if (ld) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline stage with valid/ready handshakes, 2-entry skid, flush and bubble zeroing.
// Optional stall counter output enabled by defining IDEX_STALL_CNT_EN.
module idex_skid_stage
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              C,
    input  logic              R,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_d1,
    input  logic [DATA_W-1:0] in_d2,
    input  logic [DATA_W-1:0] in_d15,
    input  logic [REG_W-1:0]  in_rs,
    input  logic [REG_W-1:0]  in_rt1,
    input  logic [REG_W-1:0]  in_rt2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_d1,
    output logic [DATA_W-1:0] out_d2,
    output logic [DATA_W-1:0] out_d15,
    output logic [REG_W-1:0]  out_rs,
    output logic [REG_W-1:0]  out_rt1,
    output logic [REG_W-1:0]  out_rt2,
    output logic [REG_W-1:0]  out_rd,
`ifdef IDEX_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam int PW = payload_w(DATA_W, REG_W, CTRL_W);

    idex_state_e       state_r;
    idex_state_e       state_nx_s;
    logic              main_valid_s;
    logic              skid_valid_s;
    logic              accept_s;
    logic              consume_s;
    logic              main_ld_s;
    logic              skid_ld_s;
    logic              main_sel_skid_s;
    logic [PW-1:0]     in_pl_s;
    logic [PW-1:0]     main_d_s;
    logic [PW-1:0]     main_q_s;
    logic [PW-1:0]     skid_q_s;
    logic [CTRL_W-1:0] main_ctrl_s;

    assign main_valid_s = (state_r != ST_EMPTY);
    assign skid_valid_s = (state_r == ST_FULL);

    // in_ready comes only from registered state, so it never loops through out_ready.
    assign in_ready  = !skid_valid_s && !R;
    assign accept_s  = in_valid && in_ready;
    assign consume_s = main_valid_s && out_ready;

    assign in_pl_s  = {in_d1, in_d2, in_d15, in_rs, in_rt1, in_rt2, in_rd, in_ctrl};
    assign main_d_s = main_sel_skid_s ? skid_q_s : in_pl_s;

    // Handshake FSM state register; reset and flush both empty the stage.
    always_ff @(posedge C) begin
        if (R) begin
            state_r <= ST_EMPTY;
        end else if (flush) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and payload load decisions for EMPTY/ONE/FULL.
    always_comb begin
        state_nx_s      = state_r;
        main_ld_s       = 1'b0;
        skid_ld_s       = 1'b0;
        main_sel_skid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nx_s = ST_ONE;
                    main_ld_s  = 1'b1;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (consume_s && accept_s) begin
                    state_nx_s = ST_ONE;
                    main_ld_s  = 1'b1;
                end else if (consume_s) begin
                    state_nx_s = ST_EMPTY;
                end else if (accept_s) begin
                    state_nx_s = ST_FULL;
                    skid_ld_s  = 1'b1;
                end else begin
                    state_nx_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (consume_s) begin
                    state_nx_s      = ST_ONE;
                    main_ld_s       = 1'b1;
                    main_sel_skid_s = 1'b1;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
    end

    // Loads are suppressed on flush; the retained payload is hidden by ctrl zeroing.
    idex_payload_reg #(.W(PW)) u_main (
        .clk (C),
        .clr (R),
        .ld  (main_ld_s && !flush),
        .d   (main_d_s),
        .q   (main_q_s)
    );

    idex_payload_reg #(.W(PW)) u_skid (
        .clk (C),
        .clr (R),
        .ld  (skid_ld_s && !flush),
        .d   (in_pl_s),
        .q   (skid_q_s)
    );

    assign {out_d1, out_d2, out_d15, out_rs, out_rt1, out_rt2, out_rd, main_ctrl_s} = main_q_s;
    assign out_valid = main_valid_s;
    assign out_ctrl  = main_valid_s ? main_ctrl_s : {CTRL_W{1'b0}};

`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles the head entry is blocked; survives flush.
    always_ff @(posedge C) begin
        if (R) begin
            stall_cnt_r <= 16'h0000;
        end else if (main_valid_s && !out_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_idex_skid_stage.sv
// Self-checking bench for idex_skid_stage: directed test-plan steps plus a random
// phase, all checked against a queue-based FIFO reference model.
module tb_idex_skid_stage;

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] d15;
        logic [3:0]  rs;
        logic [3:0]  rt1;
        logic [3:0]  rt2;
        logic [3:0]  rd;
        logic [11:0] ctrl;
    } payload_t;

    logic        C = 1'b0;
    logic        R, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_d1, in_d2, in_d15, out_d1, out_d2, out_d15;
    logic [3:0]  in_rs, in_rt1, in_rt2, in_rd, out_rs, out_rt1, out_rt2, out_rd;
    logic [11:0] in_ctrl, out_ctrl;
`ifdef IDEX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int       n_cmp = 0;
    int       n_err = 0;
    payload_t q[$];
    payload_t shown;
    bit       known;
    int       stall_m;

    always #5 C = ~C;

    idex_skid_stage dut (
        .C(C), .R(R), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_d1(in_d1), .in_d2(in_d2), .in_d15(in_d15),
        .in_rs(in_rs), .in_rt1(in_rt1), .in_rt2(in_rt2), .in_rd(in_rd),
        .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_d1(out_d1), .out_d2(out_d2), .out_d15(out_d15),
        .out_rs(out_rs), .out_rt1(out_rt1), .out_rt2(out_rt2), .out_rd(out_rd),
`ifdef IDEX_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .out_ctrl(out_ctrl)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic payload_t rand_pl();
        payload_t p;
        p.d1 = 16'($urandom);  p.d2 = 16'($urandom);  p.d15 = 16'($urandom);
        p.rs = 4'($urandom);   p.rt1 = 4'($urandom);  p.rt2 = 4'($urandom);
        p.rd = 4'($urandom);   p.ctrl = 12'($urandom);
        return p;
    endfunction

    task automatic drive(input logic v, input payload_t p);
        in_valid = v;
        in_d1 = p.d1;  in_d2 = p.d2;  in_d15 = p.d15;
        in_rs = p.rs;  in_rt1 = p.rt1; in_rt2 = p.rt2; in_rd = p.rd;
        in_ctrl = p.ctrl;
    endtask

    // Check all outputs against the model, advance one clock, update the model.
    task automatic cyc();
        payload_t cur;
        bit       acc, con;
        #1;
        chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
        chk("in_ready", 128'(in_ready), 128'(!R && q.size() < 2));
        chk("out_ctrl", 128'(out_ctrl), (q.size() > 0) ? 128'(q[0].ctrl) : 128'(0));
        if (known) begin
            chk("out_fields",
                128'({out_d1, out_d2, out_d15, out_rs, out_rt1, out_rt2, out_rd}),
                128'({shown.d1, shown.d2, shown.d15, shown.rs, shown.rt1, shown.rt2, shown.rd}));
        end
`ifdef IDEX_STALL_CNT_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(stall_m));
`endif
        cur = '{in_d1, in_d2, in_d15, in_rs, in_rt1, in_rt2, in_rd, in_ctrl};
        @(posedge C);
        #1;
        if (R) begin
            q.delete();
            shown   = '0;
            known   = 1'b1;
            stall_m = 0;
        end else begin
            acc = in_valid && (q.size() < 2);
            con = (q.size() > 0) && out_ready;
            if (q.size() > 0 && !out_ready && stall_m < 65535) stall_m++;
            if (flush) begin
                q.delete();
                known = 1'b0;
            end else begin
                if (con) void'(q.pop_front());
                if (acc) q.push_back(cur);
            end
        end
        if (q.size() > 0) begin
            shown = q[0];
            known = 1'b1;
        end
    endtask

    initial begin
        payload_t p;
        R = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, rand_pl());
        @(posedge C);
        #1;
        q.delete(); shown = '0; known = 1'b1; stall_m = 0;

        // 1. reset held two cycles with in_valid high, then release
        cyc();
        cyc();
        chk("rst_d1_zero", 128'(out_d1), 128'(0));
        R = 1'b0;
        drive(1'b0, rand_pl());
        #1;
        chk("post_rst_ready", 128'(in_ready), 128'(1));
        chk("post_rst_valid", 128'(out_valid), 128'(0));
        cyc();

        // 2. streaming with out_ready held high
        out_ready = 1'b1;
        p = rand_pl(); p.d1 = 16'h0A01; drive(1'b1, p); cyc();
        chk("stream_1", 128'(out_d1), 128'(16'h0A01));
        p = rand_pl(); p.d1 = 16'h00B3; drive(1'b1, p); cyc();
        chk("stream_2", 128'(out_d1), 128'(16'h00B3));
        p = rand_pl(); p.d1 = 16'hFFF0; drive(1'b1, p); cyc();
        chk("stream_3", 128'(out_d1), 128'(16'hFFF0));
        chk("stream_ready", 128'(in_ready), 128'(1));
        drive(1'b0, rand_pl()); cyc();

        // 3. backpressure fills main and skid, then drains in order
        out_ready = 1'b0;
        p = rand_pl(); p.rs = 4'hE; drive(1'b1, p); cyc();
        p = rand_pl(); p.rs = 4'h5; drive(1'b1, p); cyc();
        chk("skid_full_ready", 128'(in_ready), 128'(0));
        chk("skid_head_rs", 128'(out_rs), 128'(4'hE));
        drive(1'b0, rand_pl()); out_ready = 1'b1; cyc();
        chk("skid_second_rs", 128'(out_rs), 128'(4'h5));
        chk("skid_ready_back", 128'(in_ready), 128'(1));
        cyc();

        // 4. flush while FULL with an accept attempt in the same cycle
        out_ready = 1'b0;
        p = rand_pl(); p.ctrl = 12'hFFF; drive(1'b1, p); cyc();
        p = rand_pl(); p.ctrl = 12'hFFF; drive(1'b1, p); cyc();
        flush = 1'b1; drive(1'b1, rand_pl()); cyc();
        flush = 1'b0; drive(1'b0, rand_pl());
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ctrl", 128'(out_ctrl), 128'(0));
        p = rand_pl(); drive(1'b1, p); out_ready = 1'b1; cyc();
        chk("flush_next_d1", 128'(out_d1), 128'(p.d1));
        drive(1'b0, rand_pl()); cyc();

        // 5. bubble after draining an entry
        p = rand_pl(); p.ctrl = 12'h0A5; p.d15 = 16'h1234; drive(1'b1, p); cyc();
        chk("bubble_live_ctrl", 128'(out_ctrl), 128'(12'h0A5));
        drive(1'b0, rand_pl()); cyc();
        cyc();
        chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
        chk("bubble_d15", 128'(out_d15), 128'(16'h1234));

`ifdef IDEX_STALL_CNT_EN
        // 6. stall counter: ten blocked cycles, then cleared by reset
        R = 1'b1; cyc(); R = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, rand_pl()); cyc();
        drive(1'b0, rand_pl());
        for (int i = 0; i < 10; i++) cyc();
        chk("stall_ten", 128'(stall_cnt), 128'(16'd10));
        R = 1'b1; cyc(); R = 1'b0;
        chk("stall_rst", 128'(stall_cnt), 128'(0));
`endif

        // random phase: mixed valid/ready with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            R         = ($urandom_range(0, 49) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            drive(1'($urandom_range(0, 9) < 7), rand_pl());
            cyc();
        end
        R = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, rand_pl());
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/idex_skid_stage.md
Name: idex_skid_stage

Overview:
- Parametrised successor to the fixed ID/EX pipeline buffer in the 16-bit datapath.
- Carries the same field set: operand 1, operand 2, R15 operand, RS, RT1, RT2, RD, control word.
- Adds valid/ready handshakes on both sides, a 2-entry skid so upstream ready is registered, synchronous flush, and bubble control zeroing.
- Sits between decode and execute; decode drives the input side, the ALU/forwarding stage drives out_ready.

Parameters:
- DATA_W, 16, width of operand fields d1/d2/d15.
- REG_W, 4, width of register-index fields rs/rt1/rt2/rd.
- CTRL_W, 12, width of control word.

Ports:
- C  in  1  clock; all state updates on rising edge.
- R  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_d1, in_d2, in_d15  in  DATA_W each  operand fields.
- in_rs, in_rt1, in_rt2, in_rd  in  REG_W each  register indices.
- in_ctrl  in  CTRL_W  control word.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream consumes this cycle.
- out_d1, out_d2, out_d15  out  DATA_W each  operand fields.
- out_rs, out_rt1, out_rt2, out_rd  out  REG_W each  register indices.
- out_ctrl  out  CTRL_W  control word; zero whenever out_valid=0.

Behaviour:
- Storage: main register and skid register, each holding the full payload (3*DATA_W+4*REG_W+CTRL_W bits, 76 at defaults) plus a valid bit.
- in_ready = !skid_valid && !R. It is derived only from registered state and never depends combinationally on out_ready.
- Accept occurs when in_valid && in_ready. Consume occurs when out_valid && out_ready.
- States: EMPTY (main invalid), ONE (main valid, skid empty), FULL (both valid).
- EMPTY: accept -> ONE, main<=in. Otherwise stay EMPTY.
- ONE, consume and accept -> ONE, main<=in.
- ONE, consume and no accept -> EMPTY.
- ONE, no consume and accept -> FULL, skid<=in, main held.
- ONE, neither -> hold.
- FULL, consume -> ONE, main<=skid. No accept is possible because in_ready=0.
- FULL, no consume -> hold. Main payload must stay stable while out_valid && !out_ready.
- Latency: accept in cycle N -> out_valid in cycle N+1. Sustained throughput is 1 entry/cycle when out_ready is held high.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
- Reset: while R is high, both valid bits clear, all payload registers clear to 0, and in_ready=0. Every out_* port reads 0. In the first cycle after R falls, in_ready=1.
- flush (priority below R): at the edge, both valid bits clear. An entry accepted in the flush cycle is discarded. Payload registers may retain old values, but out_ctrl is forced to 0.
- Flush together with consume: the consume completes downstream and nothing remains.
- Bubble: out_ctrl = main_ctrl when out_valid=1, else 0. Other out_* fields show the last main payload.
- Mid-operation reset discards all entries, same as reset from idle.

Optional Feature:
- Macro IDEX_STALL_CNT_EN.
- Defined: adds output stall_cnt (16 bits). It increments each cycle that out_valid && !out_ready, saturates at 16'hFFFF, and clears on R. flush does not clear it.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (datapath_pkg): DATA_W/REG_W/CTRL_W defaults, a payload width constant, and localparams for states EMPTY/ONE/FULL.
- Sub-module idex_payload_reg: a width-parametrised register with synchronous clear and load enable. Instantiate it twice, for main and skid.
- FSM and handshake logic live in the top module.

Test Plan:
1. Reset: R=1 for 2 cycles with in_valid=1 -> all outputs 0 and in_ready=0; the first cycle after release has in_ready=1 and out_valid=0.
2. Streaming: out_ready=1; send d1=16'h0A01, 16'h00B3, 16'hFFF0 on consecutive cycles -> each appears one cycle later, in order, and in_ready stays 1.
3. Backpressure/skid: out_ready=0; send rs=4'hE then rs=4'h5. Expect main=E and skid=5, with in_ready=0 from the next cycle. Raise out_ready -> E then 5 are delivered, and in_ready returns to 1.
4. Flush: in FULL with ctrl=12'hFFF, assert flush together with in_valid -> next cycle out_valid=0, out_ctrl=0, and the next accepted entry is the first delivered.
5. Bubble: idle after draining an entry with ctrl=12'h0A5 -> out_ctrl=0 while out_d15 still shows the last value.
6. IDEX_STALL_CNT_EN: hold out_ready=0 for 10 cycles with an entry present -> stall_cnt=10. A subsequent R pulse gives stall_cnt=0.
